// File: rtl/vx_fpu_tag_tracker.sv
// FPU tag tracker: allocates request tags, holds per-request metadata until the response returns,
// retires out-of-order or in allocation order, and folds per-warp fflags into one CSR write per instruction.
module vx_fpu_tag_tracker #(
  parameter int unsigned DATAW     = 64,
  parameter int unsigned RESW      = 128,
  parameter int unsigned SIZE      = 8,
  parameter int unsigned IN_ORDER  = 0,
  parameter int unsigned NUM_WARPS = 4,
  parameter int unsigned TAG_W     = $clog2(SIZE),
  parameter int unsigned NW_W      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [DATAW-1:0] req_data,
  input  logic [NW_W-1:0]  req_wid,
  input  logic             req_eop,
  output logic [TAG_W-1:0] req_tag,
  input  logic             rsp_valid,
  output logic             rsp_ready,
  input  logic [TAG_W-1:0] rsp_tag,
  input  logic [RESW-1:0]  rsp_result,
  input  logic             rsp_has_fflags,
  input  logic [4:0]       rsp_fflags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] out_data,
  output logic [RESW-1:0]  out_result,
  output logic             csr_write_enable,
  output logic [NW_W-1:0]  csr_write_wid,
  output logic [4:0]       csr_write_fflags,
  output logic [TAG_W:0]   count
);

  localparam int unsigned CNT_W = TAG_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(SIZE);

  logic [DATAW-1:0] data_mem [SIZE];
  logic [RESW-1:0]  res_mem  [SIZE];
  logic [NW_W-1:0]  wid_mem  [SIZE];
  logic [4:0]       ff_mem   [SIZE];
  logic [SIZE-1:0]  eop_mem;
  logic [SIZE-1:0]  hasf_mem;

  logic [SIZE-1:0]  valid_q;
  logic [SIZE-1:0]  done_q;
  logic [TAG_W-1:0] head_q;
  logic [TAG_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;
  logic [4:0]       acc_q [NUM_WARPS];
  logic [NUM_WARPS-1:0] sticky_q;
  logic             csr_we_q;
  logic [NW_W-1:0]  csr_wid_q;
  logic [4:0]       csr_ff_q;

  logic [TAG_W-1:0] free_idx;
  logic [TAG_W-1:0] alloc_tag;
  logic             req_fire;
  logic             rsp_ok;
  logic             rsp_wr;
  logic             rel;
  logic [TAG_W-1:0] rel_tag;
  logic             ret_has;
  logic [4:0]       ret_ff;
  logic [4:0]       ret_flags;
  logic [NW_W-1:0]  ret_wid;
  logic             ret_eop;

  // Lowest-index free slot for out-of-order allocation
  always_comb begin
    free_idx = '0;
    for (int i = int'(SIZE) - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = TAG_W'(i);
    end
  end

  // Allocation, response acceptance and retirement select
  always_comb begin
    req_ready  = (count_q != FULL);
    req_fire   = req_valid & req_ready;
    alloc_tag  = (IN_ORDER != 0) ? tail_q : free_idx;
    req_tag    = alloc_tag;
    rsp_ok     = valid_q[rsp_tag] & ((IN_ORDER == 0) | ~done_q[rsp_tag]);
    rsp_wr     = 1'b0;
    out_valid  = 1'b0;
    rsp_ready  = 1'b1;
    out_data   = data_mem[rsp_tag];
    out_result = rsp_result;
    rel        = 1'b0;
    rel_tag    = rsp_tag;
    ret_has    = rsp_has_fflags;
    ret_ff     = rsp_fflags;
    if (IN_ORDER == 0) begin
      out_valid = rsp_valid;
      rsp_ready = out_ready;
      rel       = rsp_valid & out_ready & rsp_ok;
    end else begin
      rsp_wr     = rsp_valid & rsp_ok;
      out_valid  = valid_q[head_q] & done_q[head_q];
      out_data   = data_mem[head_q];
      out_result = res_mem[head_q];
      rel        = out_valid & out_ready;
      rel_tag    = head_q;
      ret_has    = hasf_mem[head_q];
      ret_ff     = ff_mem[head_q];
    end
    ret_wid   = wid_mem[rel_tag];
    ret_eop   = eop_mem[rel_tag];
    ret_flags = ret_has ? ret_ff : 5'h00;
  end

  // Slot payload storage, intentionally not reset
  always_ff @(posedge clk) begin
    if (req_fire) begin
      data_mem[alloc_tag] <= req_data;
      wid_mem[alloc_tag]  <= req_wid;
      eop_mem[alloc_tag]  <= req_eop;
    end
    if (rsp_wr) begin
      res_mem[rsp_tag]  <= rsp_result;
      hasf_mem[rsp_tag] <= rsp_has_fflags;
      ff_mem[rsp_tag]   <= rsp_fflags;
    end
  end

  // Slot state, pointers, occupancy and fflags accumulation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= '0;
      done_q    <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      sticky_q  <= '0;
      csr_we_q  <= 1'b0;
      csr_wid_q <= '0;
      csr_ff_q  <= '0;
      for (int w = 0; w < int'(NUM_WARPS); w++) acc_q[w] <= '0;
    end else begin
      if (rel) valid_q[rel_tag] <= 1'b0;
      if (req_fire) begin
        valid_q[alloc_tag] <= 1'b1;
        done_q[alloc_tag]  <= 1'b0;
      end
      if (rsp_wr) done_q[rsp_tag] <= 1'b1;
      if ((IN_ORDER != 0) && rel) head_q <= head_q + TAG_W'(1);
      if ((IN_ORDER != 0) && req_fire) tail_q <= tail_q + TAG_W'(1);
      case ({req_fire, rel})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      csr_we_q <= 1'b0;
      if (rel) begin
        if (!ret_eop) begin
          acc_q[ret_wid]    <= acc_q[ret_wid] | ret_flags;
          sticky_q[ret_wid] <= sticky_q[ret_wid] | ret_has;
        end else begin
          csr_we_q          <= sticky_q[ret_wid] | ret_has;
          csr_wid_q         <= ret_wid;
          csr_ff_q          <= acc_q[ret_wid] | ret_flags;
          acc_q[ret_wid]    <= '0;
          sticky_q[ret_wid] <= 1'b0;
        end
      end
    end
  end

  assign count            = count_q;
  assign csr_write_enable = csr_we_q;
  assign csr_write_wid    = csr_wid_q;
  assign csr_write_fflags = csr_ff_q;

  // A response must target an allocated, not-yet-completed slot
  assert property (@(posedge clk) disable iff (reset) (rsp_valid && rsp_ready) |-> rsp_ok);

endmodule
